// File: rtl/cpu_pkg.sv
// Shared types and constants for the small CPU front end.
package cpu_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    HOLD      = 2'd2
  } fetch_state_t;

  localparam byte_t DEFAULT_RESET_PC = 8'd100;

endpackage

// File: rtl/mem_port_mux.sv
// Single memory port shared by instruction fetch and execute-stage data access;
// the data access always wins and is serviced combinationally.
module mem_port_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              rst,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  input  logic              fetch_en,
  input  logic [DATA_W-1:0] fetch_addr,
  input  logic [DATA_W-1:0] RD,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] WR,
  output logic              memorywrite,
  output logic              memoryread,
  output logic              dgnt,
  output logic [DATA_W-1:0] drdata
);

  // Port arbitration: reset silences all strobes, then data access, then fetch.
  always_comb begin
    addr        = fetch_addr;
    WR          = {DATA_W{1'b0}};
    memorywrite = 1'b0;
    memoryread  = 1'b0;
    dgnt        = 1'b0;
    drdata      = {DATA_W{1'b0}};
    if (rst) begin
      memoryread = 1'b0;
    end else if (dreq) begin
      addr        = daddr;
      WR          = dwdata;
      memorywrite = dwe;
      memoryread  = ~dwe;
      dgnt        = 1'b1;
      drdata      = RD;
    end else begin
      memoryread = fetch_en;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Two-byte instruction fetch unit: opcode/operand FSM with a ready/valid
// handoff to the decoder, jump redirect, and a shared memory port.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter byte_t RESET_PC = DEFAULT_RESET_PC,
  parameter int    DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] WR,
  output logic              memorywrite,
  output logic              memoryread,
  input  logic [DATA_W-1:0] RD,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [DATA_W-1:0] ir_operand,
  output logic [DATA_W-1:0] ir_pc,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic              dgnt,
  output logic [DATA_W-1:0] drdata
);

  fetch_state_t      state_r, state_s;
  logic [DATA_W-1:0] pc_r, pc_s;
  logic [DATA_W-1:0] opcode_r, opcode_s;
  logic [DATA_W-1:0] operand_r, operand_s;
  logic [DATA_W-1:0] ipc_r, ipc_s;
  logic              valid_r;
  logic              fetch_en_s;

  // Fetch strobe is requested only in the two byte-fetch states.
  always_comb begin
    fetch_en_s = 1'b0;
    if ((state_r == FETCH_OP) || (state_r == FETCH_ARG)) begin
      fetch_en_s = 1'b1;
    end else begin
      fetch_en_s = 1'b0;
    end
  end

  mem_port_mux #(.DATA_W(DATA_W)) u_mux (
    .rst         (rst),
    .dreq        (dreq),
    .dwe         (dwe),
    .daddr       (daddr),
    .dwdata      (dwdata),
    .fetch_en    (fetch_en_s),
    .fetch_addr  (pc_r),
    .RD          (RD),
    .addr        (addr),
    .WR          (WR),
    .memorywrite (memorywrite),
    .memoryread  (memoryread),
    .dgnt        (dgnt),
    .drdata      (drdata)
  );

  // Next-state logic: redirect beats everything, a data access freezes the fetch.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    opcode_s  = opcode_r;
    operand_s = operand_r;
    ipc_s     = ipc_r;
    if (redirect) begin
      state_s = FETCH_OP;
      pc_s    = redirect_pc;
    end else if (dreq) begin
      state_s = state_r;
    end else begin
      case (state_r)
        FETCH_OP: begin
          opcode_s = RD;
          ipc_s    = pc_r;
          pc_s     = pc_r + DATA_W'(1);
          state_s  = FETCH_ARG;
        end
        FETCH_ARG: begin
          operand_s = RD;
          pc_s      = pc_r + DATA_W'(1);
          state_s   = HOLD;
        end
        HOLD: begin
          if (ir_ready) begin
            state_s = FETCH_OP;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = FETCH_OP;
        end
      endcase
    end
  end

  // State, pc and instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= FETCH_OP;
      pc_r      <= DATA_W'(RESET_PC);
      opcode_r  <= {DATA_W{1'b0}};
      operand_r <= {DATA_W{1'b0}};
      ipc_r     <= {DATA_W{1'b0}};
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      opcode_r  <= opcode_s;
      operand_r <= operand_s;
      ipc_r     <= ipc_s;
      valid_r   <= (state_s == HOLD);
    end
  end

  assign ir_valid   = valid_r;
  assign ir_opcode  = opcode_r;
  assign ir_operand = operand_r;
  assign ir_pc      = ipc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 256-byte behavioural memory.
module tb_instr_fetch;

  logic       clk;
  logic       rst;
  logic [7:0] addr, WR, RD;
  logic       memorywrite, memoryread;
  logic       ir_valid, ir_ready;
  logic [7:0] ir_opcode, ir_operand, ir_pc;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       dreq, dwe;
  logic [7:0] daddr, dwdata, drdata;
  logic       dgnt;

  logic [7:0] mem [0:255];
  logic       tb_load;
  logic [7:0] tb_laddr, tb_ldata;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(8'd100), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .WR(WR),
    .memorywrite(memorywrite), .memoryread(memoryread), .RD(RD),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_opcode(ir_opcode),
    .ir_operand(ir_operand), .ir_pc(ir_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .dreq(dreq), .dwe(dwe), .daddr(daddr),
    .dwdata(dwdata), .dgnt(dgnt), .drdata(drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign RD = mem[addr];

  always @(posedge clk) begin
    if (tb_load) mem[tb_laddr] <= tb_ldata;
    else if (memorywrite) mem[addr] <= WR;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    tb_laddr = a;
    tb_ldata = d;
    tb_load  = 1'b1;
    step();
    tb_load  = 1'b0;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'd0;
    dreq = 1'b0; dwe = 1'b0; daddr = 8'd0; dwdata = 8'd0;
    tb_load = 1'b0; tb_laddr = 8'd0; tb_ldata = 8'd0;

    for (int i = 0; i < 256; i++) load(8'(i), 8'h00);
    load(8'd100, 8'hA9); load(8'd101, 8'h00);
    load(8'd102, 8'h8D); load(8'd103, 8'h00);
    load(8'd104, 8'h42); load(8'd105, 8'h43);
    load(8'd255, 8'h11); load(8'd0,   8'h22);

    // reset state, and strobes stay quiet under dreq while in reset
    chk1("rst_valid", ir_valid, 1'b0);
    chk8("rst_opcode", ir_opcode, 8'h00);
    chk8("rst_pc", ir_pc, 8'h00);
    chk1("rst_mread", memoryread, 1'b0);
    dreq = 1'b1; dwe = 1'b1; #1;
    chk1("rst_mwrite_dreq", memorywrite, 1'b0);
    chk1("rst_dgnt_dreq", dgnt, 1'b0);
    dreq = 1'b0; dwe = 1'b0;

    // reset fetch
    step(); rst = 1'b0; #1;
    chk8("c1_addr", addr, 8'd100);
    chk1("c1_mread", memoryread, 1'b1);
    chk1("c1_valid", ir_valid, 1'b0);
    step();
    chk8("c2_addr", addr, 8'd101);
    chk1("c2_valid", ir_valid, 1'b0);
    step();
    chk1("c3_valid", ir_valid, 1'b1);
    chk8("c3_opcode", ir_opcode, 8'hA9);
    chk8("c3_operand", ir_operand, 8'h00);
    chk8("c3_pc", ir_pc, 8'd100);
    chk1("c3_mread", memoryread, 1'b0);
    step();
    chk8("c4_addr", addr, 8'd102);
    chk1("c4_valid", ir_valid, 1'b0);
    step(); step();
    chk1("c6_valid", ir_valid, 1'b1);
    chk8("c6_opcode", ir_opcode, 8'h8D);
    chk8("c6_operand", ir_operand, 8'h00);
    chk8("c6_pc", ir_pc, 8'd102);

    // backpressure
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("bp_valid", ir_valid, 1'b1);
      chk8("bp_opcode", ir_opcode, 8'h8D);
      chk8("bp_pc", ir_pc, 8'd102);
      chk1("bp_mread", memoryread, 1'b0);
      chk8("bp_addr_pc", addr, 8'd104);
    end
    ir_ready = 1'b1;
    step();
    chk8("bp_resume_addr", addr, 8'd104);
    chk1("bp_resume_valid", ir_valid, 1'b0);

    // data write during FETCH_ARG
    step();
    chk8("arg_addr", addr, 8'd105);
    dreq = 1'b1; dwe = 1'b1; daddr = 8'h10; dwdata = 8'h55; #1;
    chk1("dw_dgnt", dgnt, 1'b1);
    chk8("dw_addr", addr, 8'h10);
    chk1("dw_mwrite", memorywrite, 1'b1);
    chk1("dw_mread", memoryread, 1'b0);
    chk8("dw_wr", WR, 8'h55);
    step();
    dreq = 1'b0; dwe = 1'b0; #1;
    chk8("dw_after_addr", addr, 8'd105);
    chk1("dw_after_mread", memoryread, 1'b1);
    chk1("dw_after_dgnt", dgnt, 1'b0);
    chk8("dw_after_wr", WR, 8'h00);
    chk1("dw_after_valid", ir_valid, 1'b0);
    step();
    chk1("dw_hold_valid", ir_valid, 1'b1);
    chk8("dw_hold_opcode", ir_opcode, 8'h42);
    chk8("dw_hold_operand", ir_operand, 8'h43);
    chk8("dw_hold_pc", ir_pc, 8'd104);

    // data read back, plus redirect to 0xFF in the same HOLD cycle
    dreq = 1'b1; daddr = 8'h10; redirect = 1'b1; redirect_pc = 8'hFF; #1;
    chk8("dr_drdata", drdata, 8'h55);
    chk1("dr_mread", memoryread, 1'b1);
    chk1("dr_mwrite", memorywrite, 1'b0);
    step();
    dreq = 1'b0; redirect = 1'b0; #1;
    chk8("dr_idle_drdata", drdata, 8'h00);
    chk1("wrap_valid", ir_valid, 1'b0);
    chk8("wrap_addr0", addr, 8'hFF);
    step();
    chk8("wrap_addr1", addr, 8'h00);
    step();
    chk1("wrap_hold_valid", ir_valid, 1'b1);
    chk8("wrap_opcode", ir_opcode, 8'h11);
    chk8("wrap_operand", ir_operand, 8'h22);
    chk8("wrap_pc", ir_pc, 8'hFF);
    chk8("wrap_pc_next", addr, 8'h01);

    // redirect with handshake in HOLD
    redirect = 1'b1; redirect_pc = 8'd102;
    step();
    redirect = 1'b0; #1;
    chk1("rh_valid", ir_valid, 1'b0);
    chk8("rh_addr", addr, 8'd102);
    step(); step();
    chk1("rh_hold_valid", ir_valid, 1'b1);
    chk8("rh_opcode", ir_opcode, 8'h8D);
    chk8("rh_operand", ir_operand, 8'h00);
    chk8("rh_pc", ir_pc, 8'd102);

    // redirect coinciding with a data read in FETCH_OP
    step();
    chk8("rd_fop_addr", addr, 8'd104);
    redirect = 1'b1; redirect_pc = 8'd100; dreq = 1'b1; dwe = 1'b0; daddr = 8'd100; #1;
    chk1("rd_dgnt", dgnt, 1'b1);
    chk8("rd_drdata", drdata, 8'hA9);
    step();
    redirect = 1'b0; dreq = 1'b0; #1;
    chk8("rd_addr", addr, 8'd100);
    chk1("rd_mread", memoryread, 1'b1);

    // reset pulsed during FETCH_ARG
    step();
    chk8("rm_arg_addr", addr, 8'd101);
    rst = 1'b1; #1;
    chk1("rm_mread_rst", memoryread, 1'b0);
    step();
    rst = 1'b0; #1;
    chk1("rm_valid", ir_valid, 1'b0);
    chk8("rm_addr", addr, 8'd100);
    chk8("rm_opcode", ir_opcode, 8'h00);
    step(); step();
    chk1("rm_hold_valid", ir_valid, 1'b1);
    chk8("rm_hold_opcode", ir_opcode, 8'hA9);
    chk8("rm_hold_pc", ir_pc, 8'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
